// File: rtl/rib_pkg.sv
// Shared definitions for the RISC-V instruction/data bus arbiter.
// Master indices, default bus widths and a one-hot to index helper.
package rib_pkg;

  localparam int RIB_ADDR_W = 32;
  localparam int RIB_DATA_W = 32;

  localparam logic [1:0] RIB_M_DBG = 2'd0;
  localparam logic [1:0] RIB_M_LSU = 2'd1;
  localparam logic [1:0] RIB_M_IF  = 2'd2;

  function automatic logic [1:0] rib_onehot_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b001:  idx = RIB_M_DBG;
      3'b010:  idx = RIB_M_LSU;
      3'b100:  idx = RIB_M_IF;
      default: idx = RIB_M_DBG;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rib_prio_sel.sv
// Combinational 3-way priority select. Normal order is dbg > lsu > fetch.
// A starved fetch is promoted above the other two masters.
module rib_prio_sel
  import rib_pkg::*;
(
  input  logic [2:0] req,
  input  logic       starve_hi,
  output logic [2:0] gnt
);

  // one-hot winner selection
  always_comb begin
    gnt = 3'b000;
    if (starve_hi) begin
      if (req[RIB_M_IF]) begin
        gnt = 3'b100;
      end else if (req[RIB_M_DBG]) begin
        gnt = 3'b001;
      end else if (req[RIB_M_LSU]) begin
        gnt = 3'b010;
      end else begin
        gnt = 3'b000;
      end
    end else begin
      if (req[RIB_M_DBG]) begin
        gnt = 3'b001;
      end else if (req[RIB_M_LSU]) begin
        gnt = 3'b010;
      end else if (req[RIB_M_IF]) begin
        gnt = 3'b100;
      end else begin
        gnt = 3'b000;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
// Three-master to single-port memory arbiter with one-cycle read return
// routing and a starvation counter that guarantees instruction fetch progress.
module rib_arbiter
  import rib_pkg::*;
#(
  parameter int ADDR_W     = RIB_ADDR_W,
  parameter int DATA_W     = RIB_DATA_W,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m2_req,
  input  logic              m2_we,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [DATA_W-1:0] m2_wdata,
  output logic              m2_gnt,
  output logic              m2_rvalid,
  output logic [DATA_W-1:0] m2_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              hold_o
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX_C = CNT_W'(STARVE_MAX);

  logic [2:0]       req_s;
  logic [2:0]       gnt_s;
  logic             starve_hi_s;
  logic [1:0]       win_idx_s;
  logic             rd_vld_r;
  logic [1:0]       rd_own_r;
  logic [CNT_W-1:0] starve_cnt_r;

  assign req_s       = {m2_req, m1_req, m0_req};
  assign starve_hi_s = (starve_cnt_r == STARVE_MAX_C);
  assign win_idx_s   = rib_onehot_idx(gnt_s);

  rib_prio_sel u_prio_sel (
    .req       (req_s),
    .starve_hi (starve_hi_s),
    .gnt       (gnt_s)
  );

  assign m0_gnt = gnt_s[RIB_M_DBG];
  assign m1_gnt = gnt_s[RIB_M_LSU];
  assign m2_gnt = gnt_s[RIB_M_IF];
  assign s_req  = |gnt_s;
  assign hold_o = m2_req & ~m2_gnt;

  // steer the winning master onto the slave port; idle bus is all zeros
  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    case (gnt_s)
      3'b001: begin
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
      3'b010: begin
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end
      3'b100: begin
        s_we    = m2_we;
        s_addr  = m2_addr;
        s_wdata = m2_wdata;
      end
      default: begin
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
      end
    endcase
  end

  // remember who issued the read so the returning data finds its owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_r <= 1'b0;
      rd_own_r <= 2'd0;
    end else begin
      rd_vld_r <= s_req & ~s_we;
      rd_own_r <= win_idx_s;
    end
  end

  // count consecutive cycles in which fetch asks but is refused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= '0;
    end else if (m2_gnt || !m2_req) begin
      starve_cnt_r <= '0;
    end else if (starve_cnt_r != STARVE_MAX_C) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign m0_rvalid = rd_vld_r & (rd_own_r == RIB_M_DBG);
  assign m1_rvalid = rd_vld_r & (rd_own_r == RIB_M_LSU);
  assign m2_rvalid = rd_vld_r & (rd_own_r == RIB_M_IF);
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m2_rdata  = s_rdata;

endmodule
